cc_arbiter: RTL and testbench

- Packet-level round-robin arbiter sharing the single PCIe completer-completion (CC) AXI4-Stream port, 64-bit, between NUM_REQ completion sources (host_pio read completions, eth_top register-read completions, ...).
- Grants are locked for a whole TLP: from the first accepted beat through the beat carrying tlast.
- Output goes through a 2-entry skid buffer so the arbiter's ready path is registered toward the PCIe core.

---
 rtl/pcie_cc_pkg.sv | 27 ++
 rtl/cc_arbiter_if.sv | 39 +++
 rtl/cc_skid_buf.sv | 59 +++++
 rtl/cc_arbiter.sv | 136 +++++++++++++
 tb/tb_cc_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_cc_pkg.sv
// Shared types and widths for the PCIe completer-completion (CC) path.
package pcie_cc_pkg;

  localparam int CC_DATA_WIDTH   = 64;
  localparam int CC_KEEP_WIDTH   = CC_DATA_WIDTH / 32;
  localparam int CC_TUSER_WIDTH  = 33;
  localparam int CQ_TUSER_WIDTH  = 85;
  localparam int CC_TREADY_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CC_DATA_WIDTH-1:0]  tdata;
    logic [CC_TUSER_WIDTH-1:0] tuser;
    logic [CC_KEEP_WIDTH-1:0]  tkeep;
    logic                      tlast;
  } cc_beat_t;

  // Modulo-n increment that also holds for non-power-of-2 n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cc_arbiter_if.sv
// CC stream bundle: NUM_REQ requester streams in, one stream out to the PCIe core.
interface cc_arbiter_if
  import pcie_cc_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32
);

  logic [NUM_REQ*C_DATA_WIDTH-1:0]   s_cc_tdata;
  logic [NUM_REQ*CC_TUSER_WIDTH-1:0] s_cc_tuser;
  logic [NUM_REQ-1:0]                s_cc_tlast;
  logic [NUM_REQ*KEEP_WIDTH-1:0]     s_cc_tkeep;
  logic [NUM_REQ-1:0]                s_cc_tvalid;
  logic [NUM_REQ-1:0]                s_cc_tready;

  logic [C_DATA_WIDTH-1:0]           m_cc_tdata;
  logic [CC_TUSER_WIDTH-1:0]         m_cc_tuser;
  logic                              m_cc_tlast;
  logic [KEEP_WIDTH-1:0]             m_cc_tkeep;
  logic                              m_cc_tvalid;
  logic [CC_TREADY_WIDTH-1:0]        m_cc_tready;

  // master: requesters plus the core's ready; slave: the arbiter.
  modport master (
    output s_cc_tdata, s_cc_tuser, s_cc_tlast, s_cc_tkeep, s_cc_tvalid,
    input  s_cc_tready,
    input  m_cc_tdata, m_cc_tuser, m_cc_tlast, m_cc_tkeep, m_cc_tvalid,
    output m_cc_tready
  );

  modport slave (
    input  s_cc_tdata, s_cc_tuser, s_cc_tlast, s_cc_tkeep, s_cc_tvalid,
    output s_cc_tready,
    output m_cc_tdata, m_cc_tuser, m_cc_tlast, m_cc_tkeep, m_cc_tvalid,
    input  m_cc_tready
  );

endinterface

// File: rtl/cc_skid_buf.sv
// Two-entry AXI-S register slice on cc_beat_t; in_ready is registered so the
// core's tready never reaches the requester-side ready combinationally.
module cc_skid_buf
  import pcie_cc_pkg::*;
(
  input  logic     user_clk,
  input  logic     reset_n,
  input  cc_beat_t in_beat,
  input  logic     in_valid,
  output logic     in_ready,
  output cc_beat_t out_beat,
  output logic     out_valid,
  input  logic     out_ready
);

  cc_beat_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  assign push      = in_valid & in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_beat  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      in_ready <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/cc_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe CC stream among NUM_REQ
// completion sources; a grant is held from the first beat through tlast.
//
// state | meaning
// IDLE  | no grant; pick the next valid requester searching up from rr_ptr
// LOCK  | grant held; forward the granted requester's beats until tlast
module cc_arbiter
  import pcie_cc_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int NUM_REQ      = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                         user_clk,
  input  logic                         reset_n,
  cc_arbiter_if.slave                  cc,
  output logic [NUM_REQ*CNT_WIDTH-1:0] pkt_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [NUM_REQ-1:0] tready;
  logic               push;
  logic               tlp_done;
  logic               skid_in_ready;
  cc_beat_t           beat_in;
  cc_beat_t           beat_out;
  logic               out_valid;
  logic               unused_tready_hi;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   sum;
    pick = ptr;
    // Walk from the farthest offset down so the nearest valid requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (req[sum[IDX_W-1:0]]) begin
        pick = sum[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tready   = '0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|cc.s_cc_tvalid) begin
          grant_d = rr_pick(cc.s_cc_tvalid, rr_ptr_q);
          state_d = LOCK;
        end
      end
      LOCK: begin
        tready[grant_q] = skid_in_ready;
        push            = cc.s_cc_tvalid[grant_q] & skid_in_ready;
        if (push && cc.s_cc_tlast[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(32'(grant_q), NUM_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tlp_done       = push & cc.s_cc_tlast[grant_q];
  assign cc.s_cc_tready = tready;

  always_comb begin
    beat_in       = '0;
    beat_in.tdata = cc.s_cc_tdata[32'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
    beat_in.tuser = cc.s_cc_tuser[32'(grant_q)*CC_TUSER_WIDTH +: CC_TUSER_WIDTH];
    beat_in.tkeep = cc.s_cc_tkeep[32'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    beat_in.tlast = cc.s_cc_tlast[grant_q];
  end

  cc_skid_buf u_skid (
    .user_clk  (user_clk),
    .reset_n   (reset_n),
    .in_beat   (beat_in),
    .in_valid  (push),
    .in_ready  (skid_in_ready),
    .out_beat  (beat_out),
    .out_valid (out_valid),
    .out_ready (cc.m_cc_tready[0])
  );

  assign cc.m_cc_tdata  = beat_out.tdata;
  assign cc.m_cc_tuser  = beat_out.tuser;
  assign cc.m_cc_tkeep  = beat_out.tkeep;
  assign cc.m_cc_tlast  = beat_out.tlast;
  assign cc.m_cc_tvalid = out_valid;

  // Only bit 0 of the core's tready is meaningful.
  assign unused_tready_hi = ^cc.m_cc_tready[CC_TREADY_WIDTH-1:1];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge user_clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (tlp_done && grant_q == IDX_W'(gi)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

endmodule

// File: tb/tb_cc_arbiter.sv
// Directed bench for cc_arbiter: table-driven round-robin vectors plus
// hand-written sequences for locking, back-pressure, wrap and reset.
module tb_cc_arbiter;
  import pcie_cc_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DW      = 64;
  localparam int KW      = 2;
  localparam int CW      = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } sbeat_t;

  typedef struct {
    int          req;
    logic [63:0] data;
    logic        last;
    int          delta;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [32:0] user;
    logic [1:0]  keep;
    int          cyc;
  } obeat_t;

  logic                 user_clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ*CW-1:0] pkt_cnt;
  logic [3:0]           core_ready;

  sbeat_t src0[$];
  sbeat_t src1[$];
  sbeat_t exp_q[$];
  obeat_t obs[$];
  int     cyc;
  int     n_pass;
  int     n_total;

  cc_arbiter_if #(.NUM_REQ(NUM_REQ), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) cc ();

  cc_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .NUM_REQ      (NUM_REQ),
    .CNT_WIDTH    (CW)
  ) dut (
    .user_clk (user_clk),
    .reset_n  (reset_n),
    .cc       (cc),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [32:0] user_of(input logic [63:0] d);
    return {d[7], ~d[31:0]};
  endfunction

  function automatic logic [1:0] keep_of(input logic [63:0] d);
    return ~d[1:0];
  endfunction

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void load(input int req, input logic [63:0] d, input logic l);
    sbeat_t b;
    b.data = d;
    b.last = l;
    if (req == 0) src0.push_back(b);
    else src1.push_back(b);
    exp_q.push_back(b);
  endfunction

  task automatic drive();
    cc.s_cc_tvalid = '0;
    cc.s_cc_tdata  = '0;
    cc.s_cc_tuser  = '0;
    cc.s_cc_tkeep  = '0;
    cc.s_cc_tlast  = '0;
    if (src0.size() > 0) begin
      cc.s_cc_tvalid[0]     = 1'b1;
      cc.s_cc_tdata[63:0]   = src0[0].data;
      cc.s_cc_tlast[0]      = src0[0].last;
      cc.s_cc_tuser[32:0]   = user_of(src0[0].data);
      cc.s_cc_tkeep[1:0]    = keep_of(src0[0].data);
    end
    if (src1.size() > 0) begin
      cc.s_cc_tvalid[1]     = 1'b1;
      cc.s_cc_tdata[127:64] = src1[0].data;
      cc.s_cc_tlast[1]      = src1[0].last;
      cc.s_cc_tuser[65:33]  = user_of(src1[0].data);
      cc.s_cc_tkeep[3:2]    = keep_of(src1[0].data);
    end
    cc.m_cc_tready = core_ready;
  endtask

  // Sample handshakes at the falling edge, advance sources just after the rising edge.
  task automatic cycle();
    logic f0;
    logic f1;
    obeat_t o;
    @(negedge user_clk);
    if (cc.m_cc_tvalid && cc.m_cc_tready[0]) begin
      o.data = cc.m_cc_tdata;
      o.last = cc.m_cc_tlast;
      o.user = cc.m_cc_tuser;
      o.keep = cc.m_cc_tkeep;
      o.cyc  = cyc;
      obs.push_back(o);
    end
    f0 = cc.s_cc_tvalid[0] & cc.s_cc_tready[0];
    f1 = cc.s_cc_tvalid[1] & cc.s_cc_tready[1];
    @(posedge user_clk);
    #1;
    cyc++;
    if (f0) void'(src0.pop_front());
    if (f1) void'(src1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    core_ready = 4'hF;
    src0.delete();
    src1.delete();
    drive();
    cycle();
    cycle();
    reset_n = 1'b1;
    obs.delete();
    exp_q.delete();
  endtask

  task automatic check_obs(input string tag);
    check({tag, " beat count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("%s beat%0d data", tag, i), obs[i].data, exp_q[i].data);
      check($sformatf("%s beat%0d last", tag, i), 64'(obs[i].last), 64'(exp_q[i].last));
      check($sformatf("%s beat%0d user", tag, i), 64'(obs[i].user), 64'(user_of(exp_q[i].data)));
      check($sformatf("%s beat%0d keep", tag, i), 64'(obs[i].keep), 64'(keep_of(exp_q[i].data)));
    end
  endtask

  initial begin
    vec_t       vt [8];
    int         c0;
    int         bad;
    int         unstable;
    logic [99:0] hold;

    vt[0] = '{0, 64'hA0, 1'b0, 0};
    vt[1] = '{0, 64'hA1, 1'b1, 1};
    vt[2] = '{1, 64'hB0, 1'b0, 2};
    vt[3] = '{1, 64'hB1, 1'b1, 1};
    vt[4] = '{0, 64'hC0, 1'b0, 2};
    vt[5] = '{0, 64'hC1, 1'b1, 1};
    vt[6] = '{1, 64'hD0, 1'b0, 2};
    vt[7] = '{1, 64'hD1, 1'b1, 1};

    cyc     = 0;
    n_pass  = 0;
    n_total = 0;

    // Reset state
    do_reset();
    check("rst m_tvalid", 64'(cc.m_cc_tvalid), 64'd0);
    check("rst m_tdata", cc.m_cc_tdata, 64'd0);
    check("rst s_tready", 64'(cc.s_cc_tready), 64'd0);
    check("rst pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst state", 64'(dut.state_q), 64'(IDLE));

    // Single 3-beat TLP from requester 0
    load(0, 64'h11, 1'b0);
    load(0, 64'h22, 1'b0);
    load(0, 64'h33, 1'b1);
    drive();
    c0 = cyc;
    repeat (10) cycle();
    check_obs("t1");
    if (obs.size() > 0) check("t1 first latency", 64'(obs[0].cyc - c0), 64'd2);
    check("t1 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);
    check("t1 rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

    // Both requesters continuously valid: table of inputs and expected output order/gaps
    do_reset();
    for (int i = 0; i < 8; i++) load(vt[i].req, vt[i].data, vt[i].last);
    drive();
    repeat (30) cycle();
    check("t2 beat count", 64'(obs.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check($sformatf("t2 beat%0d data", i), obs[i].data, vt[i].data);
      check($sformatf("t2 beat%0d last", i), 64'(obs[i].last), 64'(vt[i].last));
      if (i > 0)
        check($sformatf("t2 beat%0d gap", i), 64'(obs[i].cyc - obs[i-1].cyc), 64'(vt[i].delta));
    end
    check("t2 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd2);
    check("t2 pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd2);

    // Requester 0 arrives while requester 1 is mid-packet
    do_reset();
    load(1, 64'hE0, 1'b0);
    load(1, 64'hE1, 1'b0);
    load(1, 64'hE2, 1'b0);
    load(1, 64'hE3, 1'b1);
    drive();
    cycle();
    cycle();
    load(0, 64'hF0, 1'b1);
    drive();
    bad = 0;
    for (int k = 0; k < 20 && src1.size() > 0; k++) begin
      if (cc.s_cc_tready[0]) bad++;
      cycle();
    end
    check("t3 req1 drained", 64'(src1.size()), 64'd0);
    check("t3 tready0 during lock", 64'(bad), 64'd0);
    repeat (10) cycle();
    check_obs("t3");
    check("t3 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);
    check("t3 pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd1);

    // Core back-pressure for 5 cycles mid-packet
    do_reset();
    for (int i = 0; i < 6; i++) load(0, 64'hD0 + 64'(i), (i == 5));
    drive();
    repeat (3) cycle();
    check("t4 tready0 before stall", 64'(cc.s_cc_tready[0]), 64'd1);
    core_ready = 4'b1110;
    drive();
    hold = {cc.m_cc_tdata, cc.m_cc_tlast, cc.m_cc_tuser, cc.m_cc_tkeep};
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (!cc.m_cc_tvalid ||
          {cc.m_cc_tdata, cc.m_cc_tlast, cc.m_cc_tuser, cc.m_cc_tkeep} !== hold)
        unstable++;
      core_ready = {((k % 2) == 0) ? 3'b101 : 3'b010, 1'b0};
      drive();
    end
    check("t4 output stable", 64'(unstable), 64'd0);
    check("t4 tready0 when full", 64'(cc.s_cc_tready[0]), 64'd0);
    core_ready = 4'hF;
    drive();
    repeat (20) cycle();
    check_obs("t4");
    check("t4 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);

    // Back-to-back single-beat TLPs, then counter wrap
    do_reset();
    load(0, 64'h51, 1'b1);
    load(0, 64'h52, 1'b1);
    load(0, 64'h53, 1'b1);
    drive();
    repeat (15) cycle();
    check_obs("t5");
    check("t5 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd3);
    force dut.g_cnt[0].cnt_q = 16'hFFFF;
    #1;
    release dut.g_cnt[0].cnt_q;
    check("t5 pkt_cnt0 preset", 64'(pkt_cnt[15:0]), 64'hFFFF);
    load(0, 64'h54, 1'b1);
    drive();
    repeat (6) cycle();
    check("t5 pkt_cnt0 wrap", 64'(pkt_cnt[15:0]), 64'd0);
    check("t5 pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd0);

    // Reset while locked with one beat buffered
    do_reset();
    load(0, 64'h61, 1'b0);
    load(0, 64'h62, 1'b0);
    load(0, 64'h63, 1'b1);
    drive();
    cycle();
    cycle();
    check("t6 beat buffered", 64'(cc.m_cc_tvalid), 64'd1);
    check("t6 locked", 64'(dut.state_q), 64'(LOCK));
    core_ready = 4'h0;
    reset_n    = 1'b0;
    drive();
    cycle();
    check("t6 m_tvalid after rst", 64'(cc.m_cc_tvalid), 64'd0);
    check("t6 s_tready after rst", 64'(cc.s_cc_tready), 64'd0);
    check("t6 state after rst", 64'(dut.state_q), 64'(IDLE));
    reset_n    = 1'b1;
    core_ready = 4'hF;
    src0.delete();
    obs.delete();
    exp_q.delete();
    load(0, 64'h71, 1'b0);
    load(0, 64'h72, 1'b1);
    drive();
    repeat (10) cycle();
    check_obs("t6");
    check("t6 pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
